// File: rtl/pll_rst_seq_pkg.sv
// Shared types and sizing helpers for the PLL bring-up / reset sequencer.
package pll_rst_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_e;

  localparam int unsigned RetryW = 4;

  // Bits needed for a counter that runs 0 .. num_counts-1 (never zero width).
  function automatic int unsigned cnt_width(input int unsigned num_counts);
    return (num_counts <= 1) ? 1 : $clog2(num_counts);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cdc_sync2.sv
// Two-flop synchroniser with synchronous active-high reset, for level signals
// (lock/status) crossing into clk_i.
module cdc_sync2 #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_d, meta_q;
  logic [Width-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL bring-up sequencer: pulses the PLL reset, qualifies lock over a stability
// window with retry/timeout, then releases domain resets one by one.
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int unsigned CHAN_NUM            = 5,
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 256,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned CHAN_GAP_CYCLES     = 16,
  parameter int unsigned MAX_RETRY           = 3
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_locked,
  input  logic                i_soft_req,
  output logic                o_pll_reset,
  output logic [CHAN_NUM-1:0] o_chan_reset,
  output logic                o_ready,
  output logic                o_fail,
  output logic [RetryW-1:0]   o_retry_cnt,
  output logic [2:0]          o_state
);

  localparam int unsigned GapW    = cnt_width(max_u(PLL_RST_CYCLES, CHAN_GAP_CYCLES));
  localparam int unsigned StableW = cnt_width(LOCK_STABLE_CYCLES);
  localparam int unsigned TmoW    = cnt_width(LOCK_TIMEOUT_CYCLES);

  localparam logic [GapW-1:0]    PllRstLast = GapW'(PLL_RST_CYCLES - 1);
  localparam logic [GapW-1:0]    ChanGapLast = GapW'(CHAN_GAP_CYCLES - 1);
  localparam logic [StableW-1:0] StableLast = StableW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TmoW-1:0]    TmoLast = TmoW'(LOCK_TIMEOUT_CYCLES - 1);

  logic lock_s;

  cdc_sync2 #(
    .Width (1)
  ) u_lock_sync (
    .clk_i (i_clk),
    .rst_i (i_reset),
    .d_i   (i_locked),
    .q_o   (lock_s)
  );

  state_e              state_d, state_q;
  logic [GapW-1:0]     gap_d, gap_q;
  logic [StableW-1:0]  stable_d, stable_q;
  logic [TmoW-1:0]     tmo_d, tmo_q;
  logic [RetryW-1:0]   retry_d, retry_q;
  logic [CHAN_NUM-1:0] chan_reset_d, chan_reset_q;
  logic                pll_reset_d, pll_reset_q;
  logic                ready_d, ready_q;
  logic                fail_d, fail_q;

  logic [RetryW-1:0]   retry_inc;
  logic [CHAN_NUM-1:0] chan_rel;
  logic                retry_exhausted;

  always_comb begin
    retry_inc       = (retry_q == '1) ? retry_q : retry_q + 1'b1;
    retry_exhausted = (MAX_RETRY != 0) && (32'(retry_inc) == MAX_RETRY);
    // Releasing by shifting zeros in from bit 0 makes out-of-order release impossible.
    chan_rel        = chan_reset_q << 1;
  end

  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    stable_d     = stable_q;
    tmo_d        = tmo_q;
    retry_d      = retry_q;
    chan_reset_d = chan_reset_q;

    unique case (state_q)
      PLL_RST: begin
        if (gap_q == PllRstLast) begin
          state_d  = WAIT_LOCK;
          gap_d    = '0;
          stable_d = '0;
          tmo_d    = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      WAIT_LOCK: begin
        stable_d = lock_s ? stable_q + 1'b1 : '0;
        tmo_d    = tmo_q + 1'b1;
        if (lock_s && (stable_q == StableLast)) begin
          state_d = RELEASE;
          gap_d   = '0;
        end else if (tmo_q == TmoLast) begin
          retry_d = retry_inc;
          state_d = retry_exhausted ? FAIL : PLL_RST;
          gap_d   = '0;
        end
      end

      RELEASE: begin
        if (!lock_s) begin
          state_d      = PLL_RST;
          gap_d        = '0;
          chan_reset_d = '1;
        end else if (gap_q == ChanGapLast) begin
          gap_d        = '0;
          chan_reset_d = chan_rel;
          if (chan_rel == '0) begin
            state_d = RUN;
            retry_d = '0;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      RUN: begin
        if (!lock_s) begin
          state_d      = PLL_RST;
          gap_d        = '0;
          chan_reset_d = '1;
        end
      end

      FAIL: ;

      default: begin
        state_d      = PLL_RST;
        gap_d        = '0;
        chan_reset_d = '1;
      end
    endcase

    if (i_soft_req) begin
      state_d      = PLL_RST;
      gap_d        = '0;
      stable_d     = '0;
      tmo_d        = '0;
      retry_d      = '0;
      chan_reset_d = '1;
    end

    // Status flops follow the next state so every output comes straight off a register.
    pll_reset_d = (state_d == PLL_RST) || (state_d == FAIL);
    ready_d     = (state_d == RUN);
    fail_d      = (state_d == FAIL);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= PLL_RST;
      gap_q        <= '0;
      stable_q     <= '0;
      tmo_q        <= '0;
      retry_q      <= '0;
      chan_reset_q <= '1;
      pll_reset_q  <= 1'b1;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      stable_q     <= stable_d;
      tmo_q        <= tmo_d;
      retry_q      <= retry_d;
      chan_reset_q <= chan_reset_d;
      pll_reset_q  <= pll_reset_d;
      ready_q      <= ready_d;
      fail_q       <= fail_d;
    end
  end

  assign o_pll_reset  = pll_reset_q;
  assign o_chan_reset = chan_reset_q;
  assign o_ready      = ready_q;
  assign o_fail       = fail_q;
  assign o_retry_cnt  = retry_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: directed scenarios plus random lock/soft/reset traffic,
// all checked cycle by cycle against a timestamp-based reference model.
module tb_pll_rst_seq;

  localparam int CHAN_NUM            = 3;
  localparam int PLL_RST_CYCLES      = 4;
  localparam int LOCK_STABLE_CYCLES  = 8;
  localparam int LOCK_TIMEOUT_CYCLES = 32;
  localparam int CHAN_GAP_CYCLES     = 2;
  localparam int MAX_RETRY           = 2;
  localparam int VW                  = CHAN_NUM + 10;

  localparam int PH_PLL  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_REL  = 2;
  localparam int PH_RUN  = 3;
  localparam int PH_FAIL = 4;

  logic                i_clk = 1'b0;
  logic                i_reset = 1'b1;
  logic                i_locked = 1'b0;
  logic                i_soft_req = 1'b0;
  logic                o_pll_reset;
  logic [CHAN_NUM-1:0] o_chan_reset;
  logic                o_ready;
  logic                o_fail;
  logic [3:0]          o_retry_cnt;
  logic [2:0]          o_state;

  pll_rst_seq #(
    .CHAN_NUM            (CHAN_NUM),
    .PLL_RST_CYCLES      (PLL_RST_CYCLES),
    .LOCK_STABLE_CYCLES  (LOCK_STABLE_CYCLES),
    .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
    .CHAN_GAP_CYCLES     (CHAN_GAP_CYCLES),
    .MAX_RETRY           (MAX_RETRY)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_locked     (i_locked),
    .i_soft_req   (i_soft_req),
    .o_pll_reset  (o_pll_reset),
    .o_chan_reset (o_chan_reset),
    .o_ready      (o_ready),
    .o_fail       (o_fail),
    .o_retry_cnt  (o_retry_cnt),
    .o_state      (o_state)
  );

  always #5 i_clk = ~i_clk;

  logic [VW-1:0] obs;
  assign obs = {o_pll_reset, o_chan_reset, o_ready, o_fail, o_retry_cnt, o_state};

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase plus the cycle it was entered; outputs are derived from elapsed time.
  int m_cyc = 0;
  int m_phase = PH_PLL;
  int m_t0 = 0;
  int m_run = 0;
  int m_retry = 0;
  bit m_dly[$];

  task automatic model_edge();
    bit ls;
    int e;
    ls = m_dly[0];
    e  = m_cyc - m_t0;
    m_dly.push_back(i_locked);
    void'(m_dly.pop_front());
    if (i_reset) begin
      m_phase = PH_PLL;
      m_t0    = m_cyc + 1;
      m_retry = 0;
      m_run   = 0;
      m_dly.delete();
      m_dly.push_back(1'b0);
      m_dly.push_back(1'b0);
    end else if (i_soft_req) begin
      m_phase = PH_PLL;
      m_t0    = m_cyc + 1;
      m_retry = 0;
    end else begin
      case (m_phase)
        PH_PLL: if (e == PLL_RST_CYCLES - 1) begin
          m_phase = PH_WAIT;
          m_t0    = m_cyc + 1;
          m_run   = 0;
        end
        PH_WAIT: begin
          m_run = ls ? m_run + 1 : 0;
          if (m_run == LOCK_STABLE_CYCLES) begin
            m_phase = PH_REL;
            m_t0    = m_cyc + 1;
          end else if (e == LOCK_TIMEOUT_CYCLES - 1) begin
            if (m_retry < 15) m_retry++;
            m_phase = (MAX_RETRY != 0 && m_retry == MAX_RETRY) ? PH_FAIL : PH_PLL;
            m_t0    = m_cyc + 1;
          end
        end
        PH_REL: begin
          if (!ls) begin
            m_phase = PH_PLL;
            m_t0    = m_cyc + 1;
          end else if (e + 1 == CHAN_NUM * CHAN_GAP_CYCLES) begin
            m_phase = PH_RUN;
            m_t0    = m_cyc + 1;
            m_retry = 0;
          end
        end
        PH_RUN: if (!ls) begin
          m_phase = PH_PLL;
          m_t0    = m_cyc + 1;
        end
        default: ;
      endcase
    end
    m_cyc++;
  endtask

  function automatic logic [VW-1:0] model_vec();
    logic [CHAN_NUM-1:0] ch;
    for (int k = 0; k < CHAN_NUM; k++) begin
      ch[k] = !((m_phase == PH_RUN) ||
                (m_phase == PH_REL && (m_cyc - m_t0) >= (k + 1) * CHAN_GAP_CYCLES));
    end
    return {(m_phase == PH_PLL || m_phase == PH_FAIL), ch, (m_phase == PH_RUN),
            (m_phase == PH_FAIL), 4'(m_retry), 3'(m_phase)};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    i_reset    = 1'b1;
    i_soft_req = 1'b0;
    i_locked   = 1'b0;
    tick();
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [VW-1:0] rst_vec;
    rst_vec    = {1'b1, {CHAN_NUM{1'b1}}, 1'b0, 1'b0, 4'd0, 3'd0};
    i_reset    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_locked   = 1'($urandom_range(0, 1));
      i_soft_req = 1'($urandom_range(0, 1));
      tick();
      vectors++;
      if (obs !== rst_vec) begin
        miscompares++;
        $display("FAIL reset_values i=%0d got=%b exp=%b", i, obs, rst_vec);
      end
    end
    do_reset();
    vectors++;
    if (obs !== rst_vec || obs !== model_vec()) begin
      miscompares++;
      $display("FAIL reset_cycle0 got=%b exp=%b", obs, rst_vec);
    end
  endtask

  task automatic test_bringup();
    int base;
    int cur;
    do_reset();
    base = m_cyc;
    repeat (40) begin
      i_locked = ((m_cyc - base) >= 10) ? 1'b1 : 1'b0;
      tick();
      cur = m_cyc - base;
      vectors++;
      if (obs !== model_vec()) begin
        miscompares++;
        $display("FAIL bringup cyc=%0d got=%b exp=%b", cur, obs, model_vec());
      end
      if (cur == 3 || cur == 4) begin
        vectors++;
        if (o_pll_reset !== (cur == 3) || o_state !== ((cur == 3) ? 3'd0 : 3'd1)) begin
          miscompares++;
          $display("FAIL bringup_pll_window cyc=%0d got=%b/%0d", cur, o_pll_reset, o_state);
        end
      end
      if (cur == 20) begin
        vectors++;
        if (o_state !== 3'd2) begin
          miscompares++;
          $display("FAIL bringup_release_entry got=%0d exp=2", o_state);
        end
      end
      if (cur == 22 || cur == 24 || cur == 26) begin
        logic [CHAN_NUM-1:0] exp_ch;
        exp_ch = (cur == 22) ? 3'b110 : (cur == 24) ? 3'b100 : 3'b000;
        vectors++;
        if (o_chan_reset !== exp_ch || o_ready !== (cur == 26)) begin
          miscompares++;
          $display("FAIL bringup_chan cyc=%0d got=%b rdy=%b exp=%b", cur, o_chan_reset,
                   o_ready, exp_ch);
        end
      end
    end
  endtask

  task automatic test_lock_loss_run();
    int low_len;
    repeat ($urandom_range(0, 5)) begin
      tick();
      vectors++;
      if (obs !== model_vec()) begin
        miscompares++;
        $display("FAIL loss_pre got=%b exp=%b", obs, model_vec());
      end
    end
    low_len = int'($urandom_range(1, 2));
    for (int k = 0; k < 3; k++) begin
      i_locked = (k < low_len) ? 1'b0 : 1'b1;
      tick();
      vectors++;
      if (obs !== model_vec()) begin
        miscompares++;
        $display("FAIL loss_run k=%0d got=%b exp=%b", k, obs, model_vec());
      end
    end
    vectors++;
    if (o_chan_reset !== 3'b111 || o_ready !== 1'b0 || o_state !== 3'd0 ||
        o_retry_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL loss_run_t3 got=%b/%b/%0d/%0d exp=111/0/0/0", o_chan_reset, o_ready,
               o_state, o_retry_cnt);
    end
    i_locked = 1'b1;
    repeat (40) begin
      tick();
      vectors++;
      if (obs !== model_vec()) begin
        miscompares++;
        $display("FAIL loss_relock got=%b exp=%b", obs, model_vec());
      end
    end
    vectors++;
    if (o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL loss_relock_ready got=%b exp=1", o_ready);
    end
  endtask

  task automatic test_loss_release_retry();
    int base;
    int cur;
    do_reset();
    base = m_cyc;
    repeat (53) begin
      cur      = m_cyc - base;
      i_locked = (cur >= 36 && cur != 49) ? 1'b1 : 1'b0;
      tick();
      cur = m_cyc - base;
      vectors++;
      if (obs !== model_vec()) begin
        miscompares++;
        $display("FAIL loss_rel cyc=%0d got=%b exp=%b", cur, obs, model_vec());
      end
      if (cur == 52) begin
        vectors++;
        if (o_state !== 3'd0 || o_retry_cnt !== 4'd1 || o_chan_reset !== 3'b111) begin
          miscompares++;
          $display("FAIL loss_rel_retry_kept got=%0d/%0d/%b exp=0/1/111", o_state,
                   o_retry_cnt, o_chan_reset);
        end
      end
    end
  endtask

  task automatic test_timeout_fail();
    int base;
    int cur;
    do_reset();
    base = m_cyc;
    repeat (80) begin
      tick();
      cur = m_cyc - base;
      vectors++;
      if (obs !== model_vec()) begin
        miscompares++;
        $display("FAIL timeout cyc=%0d got=%b exp=%b", cur, obs, model_vec());
      end
      if (cur == 36 || cur == 40) begin
        vectors++;
        if (o_retry_cnt !== 4'd1 || o_state !== ((cur == 36) ? 3'd0 : 3'd1)) begin
          miscompares++;
          $display("FAIL timeout_retry1 cyc=%0d got=%0d/%0d", cur, o_retry_cnt, o_state);
        end
      end
      if (cur == 72 || cur == 80) begin
        vectors++;
        if (o_state !== 3'd4 || o_fail !== 1'b1 || o_pll_reset !== 1'b1 ||
            o_retry_cnt !== 4'd2 || o_chan_reset !== 3'b111) begin
          miscompares++;
          $display("FAIL timeout_fail cyc=%0d got=%0d/%b/%b/%0d exp=4/1/1/2", cur, o_state,
                   o_fail, o_pll_reset, o_retry_cnt);
        end
      end
    end
  endtask

  task automatic test_soft_req();
    i_soft_req = 1'b1;
    tick();
    i_soft_req = 1'b0;
    vectors++;
    if (o_state !== 3'd0 || o_fail !== 1'b0 || o_retry_cnt !== 4'd0 ||
        o_pll_reset !== 1'b1 || obs !== model_vec()) begin
      miscompares++;
      $display("FAIL soft_from_fail got=%b exp=%b", obs, model_vec());
    end
    i_locked = 1'b1;
    repeat (35) tick();
    for (int k = 0; k < 3; k++) begin
      i_locked   = 1'b0;
      i_soft_req = (k == 2) ? 1'b1 : 1'b0;
      tick();
    end
    i_soft_req = 1'b0;
    vectors++;
    if (o_state !== 3'd0 || o_retry_cnt !== 4'd0 || o_chan_reset !== 3'b111 ||
        obs !== model_vec()) begin
      miscompares++;
      $display("FAIL soft_with_loss got=%b exp=%b", obs, model_vec());
    end
  endtask

  task automatic test_glitch();
    int base;
    int cur;
    do_reset();
    base = m_cyc;
    repeat (32) begin
      cur      = m_cyc - base;
      i_locked = (cur >= 10 && cur != 15) ? 1'b1 : 1'b0;
      tick();
      cur = m_cyc - base;
      vectors++;
      if (obs !== model_vec()) begin
        miscompares++;
        $display("FAIL glitch cyc=%0d got=%b exp=%b", cur, obs, model_vec());
      end
      if (cur == 25 || cur == 26 || cur == 27) begin
        vectors++;
        if (o_state !== ((cur == 25) ? 3'd1 : 3'd2) || o_chan_reset !== 3'b111) begin
          miscompares++;
          $display("FAIL glitch_release cyc=%0d got=%0d/%b", cur, o_state, o_chan_reset);
        end
      end
    end
  endtask

  task automatic test_reset_mid_release();
    int base;
    int cur;
    do_reset();
    base = m_cyc;
    while ((m_cyc - base) < 23) begin
      i_locked = ((m_cyc - base) >= 10) ? 1'b1 : 1'b0;
      tick();
    end
    vectors++;
    if (o_chan_reset !== 3'b110) begin
      miscompares++;
      $display("FAIL midrel_chan0 got=%b exp=110", o_chan_reset);
    end
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    base    = m_cyc;
    vectors++;
    if (obs !== {1'b1, 3'b111, 1'b0, 1'b0, 4'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL midrel_reset got=%b exp=%b", obs, {1'b1, 3'b111, 8'd0});
    end
    repeat (8) begin
      tick();
      cur = m_cyc - base;
      vectors++;
      if (obs !== model_vec() || o_pll_reset !== (cur < PLL_RST_CYCLES)) begin
        miscompares++;
        $display("FAIL midrel_restart cyc=%0d got=%b exp=%b", cur, obs, model_vec());
      end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        i_locked = ~i_locked;
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6))
                                            : int'($urandom_range(20, 90));
      end
      hold--;
      i_soft_req = ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0;
      i_reset    = ($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0;
      tick();
      vectors++;
      if (obs !== model_vec()) begin
        miscompares++;
        $display("FAIL random i=%0d got=%b exp=%b", i, obs, model_vec());
      end
    end
    i_reset    = 1'b0;
    i_soft_req = 1'b0;
  endtask

  initial begin
    m_dly.push_back(1'b0);
    m_dly.push_back(1'b0);
    test_reset();
    test_bringup();
    test_lock_loss_run();
    test_loss_release_retry();
    test_timeout_fail();
    test_soft_req();
    test_glitch();
    test_reset_mid_release();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired after %0d vectors", vectors);
    $fatal(1, "watchdog");
  end

endmodule
